serial_word_capture: RTL and testbench

- Downstream consumer of the single-bit D flip-flop stage: takes the registered serial bit (the flip-flop Q) plus a sample strobe and assembles WIDTH-bit words.
- Each word is presented on a one-entry output buffer with a valid/ready handshake, and a sticky overrun flag reports any words lost.
- Sits between the bit-level flip-flop stage and any word-level consumer.

---
 rtl/serial_word_capture.sv | 98 +++++++++
 tb/tb_serial_word_capture.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/serial_word_capture.sv
// Serial-to-word capture: LSB-first shift register feeding a one-entry valid/ready buffer.
// Defining SERIAL_WORD_PARITY_EN adds registered even parity on out_parity.
module serial_word_capture #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             din,
  input  logic             din_en,
  input  logic             clear,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_parity,
  output logic             overrun,
  output logic [CNT_W-1:0] bit_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] next_word;
  logic             word_done;
  buf_state_t       state;

  assign next_word = {din, shreg[WIDTH-1:1]};
  assign word_done = din_en && (bit_count == CNT_W'(WIDTH-1));

  // Shift path: only din_en advances it; clear wins over din_en.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shreg     <= '0;
      bit_count <= '0;
    end else if (clear) begin
      shreg     <= '0;
      bit_count <= '0;
    end else if (din_en) begin
      shreg     <= next_word;
      bit_count <= word_done ? '0 : bit_count + 1'b1;
    end
  end

  // Output buffer FSM. A completing word always loads when EMPTY or when the
  // current word is being accepted on the same edge; otherwise it is dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      overrun   <= 1'b0;
    end else if (clear) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (word_done) begin
            state     <= FULL;
            out_valid <= 1'b1;
            out_data  <= next_word;
          end
        end
        FULL: begin
          if (word_done && out_ready) begin
            out_data <= next_word;
          end else if (word_done) begin
            overrun <= 1'b1;
          end else if (out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef SERIAL_WORD_PARITY_EN
  logic load_word;
  assign load_word = word_done && ((state == EMPTY) || out_ready);

  // Parity tracks out_data exactly: same load condition, survives clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      out_parity <= 1'b0;
    else if (!clear && load_word)
      out_parity <= ^next_word;
  end
`else
  assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_capture.sv
// Directed bench for serial_word_capture (WIDTH=8), hand-computed expectations.
module tb_serial_word_capture;

  localparam int WIDTH = 8;
  localparam int CNT_W = 5;
`ifdef SERIAL_WORD_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             din, din_en, clear, out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid, out_parity, overrun;
  logic [CNT_W-1:0] bit_count;

  int vectors    = 0;
  int miscompares = 0;

  serial_word_capture #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .din(din), .din_en(din_en), .clear(clear),
    .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
    .out_parity(out_parity), .overrun(overrun), .bit_count(bit_count)
  );

  always #5 clock = ~clock;

  // One clock: inputs applied 1ns after the previous edge, outputs sampled 1ns after this one.
  task automatic step(input logic en, input logic d, input logic rdy, input logic clr);
    din_en = en; din = d; out_ready = rdy; clear = clr;
    @(posedge clock); #1;
    din_en = 1'b0; clear = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; din = 1'b0; din_en = 1'b0; clear = 1'b0; out_ready = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", out_valid); end
    vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h want 00", out_data); end
    vectors++; if (bit_count !== 5'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", bit_count); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got %b want 0", overrun); end
    vectors++; if (out_parity !== 1'b0) begin miscompares++; $display("FAIL reset_parity got %b want 0", out_parity); end
    reset = 1'b1;
    step(0, 0, 0, 0);
  endtask

  task automatic test_alternating;
    for (int i = 0; i < 8; i++) begin
      step(1, logic'(i % 2), 1, 0);
      vectors++;
      if (bit_count !== CNT_W'((i + 1) % 8)) begin
        miscompares++; $display("FAIL alt_count[%0d] got %0d want %0d", i, bit_count, (i + 1) % 8);
      end
      if (i < 7) begin
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL alt_early_valid[%0d] got %b want 0", i, out_valid); end
      end
    end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL alt_valid got %b want 1", out_valid); end
    vectors++; if (out_data !== 8'hAA) begin miscompares++; $display("FAIL alt_data got %h want aa", out_data); end
    vectors++; if (out_parity !== 1'b0) begin miscompares++; $display("FAIL alt_parity got %b want 0", out_parity); end
    step(0, 0, 1, 0);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL alt_drain got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 16; i++) begin
      step(1, logic'(i < 8), 0, 0);
      if (i >= 7) begin
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid[%0d] got %b want 1", i, out_valid); end
        vectors++; if (out_data !== 8'hFF) begin miscompares++; $display("FAIL bp_data[%0d] got %h want ff", i, out_data); end
        vectors++;
        if (overrun !== logic'(i == 15)) begin
          miscompares++; $display("FAIL bp_overrun[%0d] got %b want %b", i, overrun, (i == 15));
        end
      end
    end
    vectors++; if (out_parity !== 1'b0) begin miscompares++; $display("FAIL bp_parity got %b want 0", out_parity); end
    step(0, 0, 1, 0);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain got %b want 0", out_valid); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL bp_sticky got %b want 1", overrun); end
    step(0, 0, 0, 1);
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL bp_clear_ovr got %b want 0", overrun); end
    vectors++; if (out_data !== 8'hFF) begin miscompares++; $display("FAIL bp_clear_keep got %h want ff", out_data); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] w0, w1;
    w0 = 8'hC3; w1 = 8'h01;
    for (int i = 0; i < 8; i++) step(1, w0[i], 0, 0);
    vectors++; if (out_data !== 8'hC3 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL b2b_first got %h/%b want c3/1", out_data, out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      step(1, w1[i], logic'(i == 7), 0);
      if (i == 6) begin
        vectors++; if (out_data !== 8'hC3) begin miscompares++; $display("FAIL b2b_hold got %h want c3", out_data); end
      end
    end
    vectors++; if (out_data !== 8'h01) begin miscompares++; $display("FAIL b2b_data got %h want 01", out_data); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid got %b want 1", out_valid); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL b2b_overrun got %b want 0", overrun); end
    vectors++; if (out_parity !== PAR_ON) begin miscompares++; $display("FAIL b2b_parity got %b want %b", out_parity, PAR_ON); end
    step(0, 0, 1, 0);
  endtask

  task automatic test_gapped;
    logic [7:0] w;
    w = 8'h03;
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < 2; g++) begin
        step(0, 1, 0, 0);
        vectors++; if (bit_count !== CNT_W'(i)) begin
          miscompares++; $display("FAIL gap_idle[%0d] got %0d want %0d", i, bit_count, i);
        end
      end
      step(1, w[i], 0, 0);
    end
    vectors++; if (out_data !== 8'h03 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL gap_data got %h/%b want 03/1", out_data, out_valid);
    end
    vectors++; if (out_parity !== 1'b0) begin miscompares++; $display("FAIL gap_parity got %b want 0", out_parity); end
    step(0, 0, 1, 0);
  endtask

  task automatic test_clear;
    logic [7:0] w;
    w = 8'h5A;
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
    vectors++; if (bit_count !== 5'd5) begin miscompares++; $display("FAIL clr_pre got %0d want 5", bit_count); end
    step(1, 1, 0, 1);
    vectors++; if (bit_count !== 5'd0) begin miscompares++; $display("FAIL clr_count got %0d want 0", bit_count); end
    for (int i = 0; i < 8; i++) step(1, w[i], 0, 0);
    vectors++; if (out_data !== 8'h5A || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL clr_data got %h/%b want 5a/1", out_data, out_valid);
    end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL clr_overrun got %b want 0", overrun); end
    vectors++; if (out_parity !== 1'b0) begin miscompares++; $display("FAIL clr_parity got %b want 0", out_parity); end
  endtask

  task automatic test_async_reset;
    logic [7:0] w;
    // Word 5A from the previous test is still held; add three partial bits.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
    vectors++; if (bit_count !== 5'd3 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL ar_pre got %0d/%b want 3/1", bit_count, out_valid);
    end
    #2 reset = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ar_valid got %b want 0", out_valid); end
    vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL ar_data got %h want 00", out_data); end
    vectors++; if (bit_count !== 5'd0) begin miscompares++; $display("FAIL ar_count got %0d want 0", bit_count); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL ar_overrun got %b want 0", overrun); end
    @(posedge clock); #1;
    reset = 1'b1;
    w = 8'h81;
    for (int i = 0; i < 8; i++) step(1, w[i], 0, 0);
    vectors++; if (out_data !== 8'h81 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL ar_restart got %h/%b want 81/1", out_data, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_alternating();
    test_backpressure();
    test_back_to_back();
    test_gapped();
    test_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
